// File: rtl/speechrec_pkg.sv
// Shared types and default sizing for the speech sequencer.
package speechrec_pkg;

  localparam int unsigned NSAMP_DEFAULT   = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    PROC   = 3'd2,
    WAITSS = 3'd3,
    XMIT   = 3'd4
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer per bit, with rise/fall detection against a third flop.
module spi_sync #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign dout = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/speech_sequencer.sv
// SPI-fed audio frame capture, processor handshake and single-byte result readback.
module speech_sequencer
  import speechrec_pkg::*;
#(
  parameter int unsigned NSAMP   = NSAMP_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        sdi,
  input  logic        ss,
  output logic        sdo,
  output logic        buf_we,
  output logic [15:0] buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        proc_start,
  input  logic        proc_done,
  input  logic [7:0]  proc_result,
  output logic        busy,
  output logic        err,
  output logic [7:0]  led
);

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  sr;
  logic [7:0]  tx;
  logic [31:0] tmr;
  logic        seen_low;

  logic [2:0] sync_lvl, sync_rise, sync_fall;
  logic       sck_rise, sck_fall, sdi_s, ss_s, ss_rise, ss_fall;
  logic       unused_sync;

  spi_sync #(.W(3)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     ({ss, sdi, sck}),
    .dout    (sync_lvl),
    .rise    (sync_rise),
    .fall    (sync_fall)
  );

  assign sck_rise    = sync_rise[0];
  assign sck_fall    = sync_fall[0];
  assign sdi_s       = sync_lvl[1];
  assign ss_s        = sync_lvl[2];
  assign ss_rise     = sync_rise[2];
  assign ss_fall     = sync_fall[2];
  assign unused_sync = ^{sync_lvl[0], sync_rise[1], sync_fall[1]};

  assign busy = (state != IDLE);
  assign sdo  = (state == XMIT) & tx[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      tx         <= '0;
      tmr        <= '0;
      seen_low   <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      led        <= '0;
      proc_start <= 1'b0;
      err        <= 1'b0;
    end else begin
      buf_we     <= 1'b0;
      proc_start <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_rise) begin
            state    <= RECV;
            bit_cnt  <= '0;
            buf_addr <= '0;
          end
        end
        RECV: begin
          // ss loss wins over any sck edge seen in the same cycle
          if (ss_fall) begin
            err     <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
          end else begin
            if (sck_rise) begin
              sr      <= {sr[6:0], sdi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                buf_we    <= 1'b1;
                buf_wdata <= {sr[6:0], sdi_s};
                led       <= {sr[6:0], sdi_s};
              end
            end
            // address advances the cycle after its write strobe
            if (buf_we) begin
              buf_addr <= buf_addr + 16'd1;
              if (buf_addr == 16'(NSAMP - 1)) begin
                state      <= PROC;
                proc_start <= 1'b1;
                tmr        <= '0;
              end
            end
          end
        end
        PROC: begin
          tmr <= tmr + 32'd1;
          if (!proc_start && proc_done) begin
            tx       <= proc_result;
            state    <= WAITSS;
            seen_low <= 1'b0;
          end else if (tmr == 32'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        WAITSS: begin
          if (!ss_s) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            state   <= XMIT;
            bit_cnt <= '0;
          end
        end
        XMIT: begin
          if (ss_fall) begin
            state <= IDLE;
          end else if (sck_fall) begin
            if (bit_cnt == 3'd7) begin
              state <= IDLE;
            end else begin
              tx      <= {tx[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
